// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, memory
// burst-size encodings and the reset PC shared with mainMem.
package fetch_pkg;

    // PC after reset; mainMem maps its instruction region at this address.
    localparam logic [31:0] START_ADDRESS = 32'h8002_0000;

    // Fetch FSM state encoding.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    // mem_acc_size encodings for the supported burst lengths.
    localparam logic [1:0] ACC_SIZE_1  = 2'b00;
    localparam logic [1:0] ACC_SIZE_4  = 2'b01;
    localparam logic [1:0] ACC_SIZE_8  = 2'b10;
    localparam logic [1:0] ACC_SIZE_16 = 2'b11;

    // Map a burst length in words onto the memory's access-size code.
    function automatic logic [1:0] acc_size_for(input int unsigned burst_len);
        logic [1:0] code;
        case (burst_len)
            32'd1:   code = ACC_SIZE_1;
            32'd4:   code = ACC_SIZE_4;
            32'd8:   code = ACC_SIZE_8;
            32'd16:  code = ACC_SIZE_16;
            default: code = ACC_SIZE_4;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundles of the fetch stage: the burst-read port towards mainMem and the
// (pc, insn) valid/ready port towards decode.
interface fetch_mem_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic                    mem_en;
    logic                    mem_wren;
    logic [1:0]              mem_acc_size;
    logic                    mem_busy;
    logic [DATA_SIZE-1:0]    mem_d_out;

    modport master (
        output mem_addr, mem_en, mem_wren, mem_acc_size,
        input  mem_busy, mem_d_out
    );

    modport slave (
        input  mem_addr, mem_en, mem_wren, mem_acc_size,
        output mem_busy, mem_d_out
    );
endinterface

interface fetch_dec_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    logic                    dec_valid;
    logic                    dec_ready;
    logic [DATA_SIZE-1:0]    dec_insn;
    logic [ADDRESS_SIZE-1:0] dec_pc;

    modport master (
        output dec_valid, dec_insn, dec_pc,
        input  dec_ready
    );

    modport slave (
        input  dec_valid, dec_insn, dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_unit_inst_queue.sv
// Circular instruction queue: power-of-two depth, wrap-around pointers,
// occupancy count 0..DEPTH, flush dominating push/pop, head shown combinationally
// (all-zero while empty).
module inst_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                  valid,
    output logic [WIDTH-1:0]      head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // A push into a full queue is only accepted when a pop frees the slot.
    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
    assign push_ok_s = push && ((count_r != FULL_COUNT) || pop_ok_s);

    // Pointer and occupancy tracking; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            store_r[wr_ptr_r] <= push_data;
        end
    end

    // Head entry, forced to zero while the queue is empty.
    always_comb begin
        head_data = {WIDTH{1'b0}};
        if (valid) begin
            head_data = store_r[rd_ptr_r];
        end else begin
            head_data = {WIDTH{1'b0}};
        end
    end

    assign valid = (count_r != {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, burst reads from mainMem, redirect
// flush/abort and fault detection. Fetched words are buffered in inst_queue
// and handed to decode as (pc, insn) pairs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      ADDRESS_SIZE  = 32,
    parameter int                      DATA_SIZE     = 32,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = fetch_pkg::START_ADDRESS,
    parameter int                      BURST_LEN     = 4,
    parameter int                      QDEPTH        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_en,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    fetch_mem_if.master             mem,
    fetch_dec_if.master             dec,
    output logic                    fetch_fault
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int EW = ADDRESS_SIZE + DATA_SIZE;
    localparam logic [4:0]              LAST_BEAT = 5'(BURST_LEN - 1);
    localparam logic [CW-1:0]           MAX_START_COUNT = CW'(QDEPTH - BURST_LEN);
    localparam logic [ADDRESS_SIZE-1:0] WORD_STEP = ADDRESS_SIZE'(4);
    localparam logic [1:0]              ACC_SIZE = acc_size_for(BURST_LEN);

    logic [1:0]              state_r;
    logic [ADDRESS_SIZE-1:0] fetch_pc_r;
    logic [ADDRESS_SIZE-1:0] mem_addr_r;
    logic                    mem_en_r;
    logic [4:0]              beat_cnt_r;
    logic                    fault_r;

    logic                    start_s;
    logic                    beat_s;
    logic                    q_push_s;
    logic                    q_pop_s;
    logic                    q_valid_s;
    logic [CW-1:0]           q_count_s;
    logic [EW-1:0]           q_head_s;

    // A burst only starts when the whole burst is guaranteed to fit.
    assign start_s  = (state_r == IDLE) && fetch_en && !fault_r && !redirect_valid &&
                      (q_count_s <= MAX_START_COUNT);
    assign beat_s   = (state_r == BURST) && mem_en_r && mem.mem_busy;
    // A redirect in the same cycle discards the returning beat and the pop.
    assign q_push_s = beat_s && !redirect_valid;
    assign q_pop_s  = q_valid_s && dec.dec_ready && !redirect_valid;

    // Fetch FSM and address generation; redirect overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            fetch_pc_r <= START_ADDRESS;
            mem_addr_r <= START_ADDRESS;
            mem_en_r   <= 1'b0;
            beat_cnt_r <= 5'd0;
            fault_r    <= 1'b0;
        end else if (redirect_valid) begin
            state_r    <= IDLE;
            fetch_pc_r <= {redirect_pc[ADDRESS_SIZE-1:2], 2'b00};
            mem_en_r   <= 1'b0;
            beat_cnt_r <= 5'd0;
            fault_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r    <= BURST;
                        mem_en_r   <= 1'b1;
                        mem_addr_r <= fetch_pc_r;
                        beat_cnt_r <= 5'd0;
                    end
                end
                BURST: begin
                    if (mem.mem_busy) begin
                        mem_addr_r <= mem_addr_r + WORD_STEP;
                        if (beat_cnt_r == LAST_BEAT) begin
                            state_r    <= IDLE;
                            mem_en_r   <= 1'b0;
                            fetch_pc_r <= mem_addr_r + WORD_STEP;
                            beat_cnt_r <= 5'd0;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 5'd1;
                        end
                    end else begin
                        // Memory refused the address: park until redirected.
                        state_r    <= FAULT;
                        mem_en_r   <= 1'b0;
                        beat_cnt_r <= 5'd0;
                        fault_r    <= 1'b1;
                    end
                end
                FAULT: begin
                    state_r  <= FAULT;
                    mem_en_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    mem_en_r   <= 1'b0;
                    beat_cnt_r <= 5'd0;
                end
            endcase
        end
    end

    inst_queue #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push_s),
        .push_data ({mem_addr_r, mem.mem_d_out}),
        .pop       (q_pop_s),
        .flush     (redirect_valid),
        .count     (q_count_s),
        .valid     (q_valid_s),
        .head_data (q_head_s)
    );

    assign mem.mem_addr     = mem_addr_r;
    assign mem.mem_en       = mem_en_r;
    assign mem.mem_wren     = 1'b0;
    assign mem.mem_acc_size = ACC_SIZE;

    assign dec.dec_valid = q_valid_s;
    assign dec.dec_pc    = q_head_s[EW-1:DATA_SIZE];
    assign dec.dec_insn  = q_head_s[DATA_SIZE-1:0];

    assign fetch_fault = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a combinational mainMem model serves
// bursts, a scoreboard queue holds the (pc, insn) pairs decode must see.
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];
    logic [31:0] burst_obs[$];
    logic [1:0]  acc_obs[$];
    logic        prev_en = 1'b0;

    fetch_mem_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) mem_bus ();
    fetch_dec_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) dec_bus ();

    fetch_unit #(
        .ADDRESS_SIZE  (32),
        .DATA_SIZE     (32),
        .START_ADDRESS (32'h8002_0000),
        .BURST_LEN     (4),
        .QDEPTH        (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem            (mem_bus),
        .dec            (dec_bus),
        .fetch_fault    (fetch_fault)
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3C3_3C3C;
    endfunction

    function automatic logic mapped(input logic [31:0] a);
        return (a >= 32'h8002_0000) && (a < 32'h8004_0000);
    endfunction

    // mainMem model: answers every cycle the enabled address is mapped.
    assign mem_bus.mem_busy  = mem_bus.mem_en && mapped(mem_bus.mem_addr);
    assign mem_bus.mem_d_out = mem_bus.mem_busy ? word_at(mem_bus.mem_addr) : 32'h0;

    always #5 clk = ~clk;

    // Record every burst start (rising mem_en) shortly after the clock edge.
    always @(posedge clk) begin
        #1;
        if (mem_bus.mem_en && !prev_en) begin
            burst_obs.push_back(mem_bus.mem_addr);
            acc_obs.push_back(mem_bus.mem_acc_size);
        end
        prev_en <= mem_bus.mem_en;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [31:0] base, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            sb_q.push_back({a, word_at(a)});
        end
    endtask

    // Accept one entry from decode (called on a negedge, returns one negedge after the pop).
    task automatic pop_one(input string name);
        int w;
        logic [63:0] exp_v;
        w = 0;
        dec_bus.dec_ready = 1'b1;
        while (dec_bus.dec_valid !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (dec_bus.dec_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: dec_valid=%b after 40 cycles, required 1", name, dec_bus.dec_valid);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected entry pc=%h, required none", name, dec_bus.dec_pc);
        end else begin
            exp_v = sb_q.pop_front();
            if ({dec_bus.dec_pc, dec_bus.dec_insn} !== exp_v) begin
                errors++;
                $display("FAIL %s: pc=%h insn=%h, required pc=%h insn=%h", name,
                         dec_bus.dec_pc, dec_bus.dec_insn, exp_v[63:32], exp_v[31:0]);
            end
        end
        @(negedge clk);
        dec_bus.dec_ready = 1'b0;
    endtask

    // Redirect with fetching disabled to reach a clean idle state at pc.
    task automatic cleanup(input logic [31:0] pc);
        dec_bus.dec_ready = 1'b0;
        fetch_en = 1'b0;
        redirect_pc = pc;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dec_bus.dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL cleanup_flush: dec_valid=%b, required 0", dec_bus.dec_valid);
        end
        sb_q.delete();
        burst_obs.delete();
        acc_obs.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dec_bus.dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b, required 0", mem_bus.mem_en); end
        checks++; if (mem_bus.mem_addr !== START) begin errors++; $display("FAIL rst_mem_addr: got %h, required %h", mem_bus.mem_addr, START); end
        checks++; if (dec_bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid: got %b, required 0", dec_bus.dec_valid); end
        checks++; if (dec_bus.dec_insn !== 32'h0) begin errors++; $display("FAIL rst_dec_insn: got %h, required 0", dec_bus.dec_insn); end
        checks++; if (dec_bus.dec_pc !== 32'h0) begin errors++; $display("FAIL rst_dec_pc: got %h, required 0", dec_bus.dec_pc); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b, required 0", fetch_fault); end
        checks++; if (mem_bus.mem_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b, required 0", mem_bus.mem_wren); end
        checks++; if (mem_bus.mem_acc_size !== 2'b01) begin errors++; $display("FAIL rst_acc_size: got %b, required 01", mem_bus.mem_acc_size); end
    endtask

    task automatic test_sequential();
        push_exp(START, 8);
        rst_n = 1'b1;
        fetch_en = 1'b1;
        repeat (8) pop_one("seq_order");
        fetch_en = 1'b0;
        checks++;
        if (burst_obs.size() < 2) begin
            errors++; $display("FAIL seq_bursts: %0d burst starts, required at least 2", burst_obs.size());
        end else if (burst_obs[0] !== START || burst_obs[1] !== START + 32'h10) begin
            errors++; $display("FAIL seq_bursts: starts %h %h, required %h %h", burst_obs[0], burst_obs[1], START, START + 32'h10);
        end
        checks++;
        if (acc_obs.size() < 1 || acc_obs[0] !== 2'b01) begin
            errors++; $display("FAIL seq_acc_size: size code missing or not 01");
        end
    endtask

    task automatic test_backpressure();
        push_exp(32'h8002_0200, 8);
        fetch_en = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (burst_obs.size() != 2) begin
            errors++; $display("FAIL bp_two_bursts: %0d burst starts, required 2", burst_obs.size());
        end else if (burst_obs[0] !== 32'h8002_0200 || burst_obs[1] !== 32'h8002_0210) begin
            errors++; $display("FAIL bp_two_bursts: starts %h %h, required 80020200 80020210", burst_obs[0], burst_obs[1]);
        end
        checks++; if (dec_bus.dec_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", dec_bus.dec_valid); end
        repeat (3) pop_one("bp_pop");
        repeat (10) @(negedge clk);
        checks++; if (burst_obs.size() != 2) begin errors++; $display("FAIL bp_no_third: %0d burst starts, required 2", burst_obs.size()); end
        pop_one("bp_pop");
        @(negedge clk);
        checks++;
        if (burst_obs.size() != 3) begin
            errors++; $display("FAIL bp_third_start: %0d burst starts, required 3", burst_obs.size());
        end else if (burst_obs[2] !== 32'h8002_0220) begin
            errors++; $display("FAIL bp_third_start: addr %h, required 80020220", burst_obs[2]);
        end
        push_exp(32'h8002_0220, 4);
        // Three beats bring the queue to 7; the fourth beat coincides with a pop.
        repeat (3) @(negedge clk);
        pop_one("full_pushpop");
        fetch_en = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (burst_obs.size() != 3) begin errors++; $display("FAIL full_no_burst: %0d burst starts, required 3", burst_obs.size()); end
        checks++; if (dec_bus.dec_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b, required 1", dec_bus.dec_valid); end
        repeat (7) pop_one("full_drain");
        checks++; if (dec_bus.dec_valid !== 1'b0) begin errors++; $display("FAIL full_empty: dec_valid %b, required 0", dec_bus.dec_valid); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL full_sb_empty: %0d entries never seen, required 0", sb_q.size()); end
    endtask

    task automatic test_redirect();
        int w;
        fetch_en = 1'b1;
        w = 0;
        while (mem_bus.mem_en !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 32'h8002_0300) begin errors++; $display("FAIL redir_first_start: en=%b addr=%h, required 1 80020300", mem_bus.mem_en, mem_bus.mem_addr); end
        @(negedge clk);
        checks++; if (dec_bus.dec_valid !== 1'b1 || dec_bus.dec_pc !== 32'h8002_0300) begin errors++; $display("FAIL redir_pre: valid=%b pc=%h, required 1 80020300", dec_bus.dec_valid, dec_bus.dec_pc); end
        redirect_pc = 32'h8002_0103;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (dec_bus.dec_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: dec_valid %b, required 0", dec_bus.dec_valid); end
        checks++; if (mem_bus.mem_en !== 1'b0) begin errors++; $display("FAIL redir_abort: mem_en %b, required 0", mem_bus.mem_en); end
        @(negedge clk);
        checks++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 32'h8002_0100) begin errors++; $display("FAIL redir_restart: en=%b addr=%h, required 1 80020100", mem_bus.mem_en, mem_bus.mem_addr); end
        fetch_en = 1'b0;
        push_exp(32'h8002_0100, 4);
        repeat (4) pop_one("redir_order");
        checks++; if (dec_bus.dec_valid !== 1'b0) begin errors++; $display("FAIL redir_empty: dec_valid %b, required 0", dec_bus.dec_valid); end
    endtask

    task automatic test_fault();
        fetch_en = 1'b1;
        @(negedge clk);
        checks++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL fault_request: en=%b addr=%h, required 1 80000000", mem_bus.mem_en, mem_bus.mem_addr); end
        @(negedge clk);
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b, required 1", fetch_fault); end
        checks++; if (mem_bus.mem_en !== 1'b0) begin errors++; $display("FAIL fault_en_drop: got %b, required 0", mem_bus.mem_en); end
        repeat (6) @(negedge clk);
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b, required 1", fetch_fault); end
        checks++; if (burst_obs.size() != 1) begin errors++; $display("FAIL fault_no_retry: %0d burst starts, required 1", burst_obs.size()); end
        redirect_pc = 32'h8002_0040;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b, required 0", fetch_fault); end
        @(negedge clk);
        checks++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 32'h8002_0040) begin errors++; $display("FAIL fault_resume: en=%b addr=%h, required 1 80020040", mem_bus.mem_en, mem_bus.mem_addr); end
        fetch_en = 1'b0;
        push_exp(32'h8002_0040, 4);
        repeat (4) pop_one("fault_resume_order");
        // Burst running off the end of mapped memory keeps the beats it got.
        cleanup(32'h8003_FFF8);
        fetch_en = 1'b1;
        push_exp(32'h8003_FFF8, 2);
        repeat (8) @(negedge clk);
        fetch_en = 1'b0;
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_partial: got %b, required 1", fetch_fault); end
        repeat (2) pop_one("fault_partial_keep");
        checks++; if (dec_bus.dec_valid !== 1'b0) begin errors++; $display("FAIL fault_partial_empty: dec_valid %b, required 0", dec_bus.dec_valid); end
    endtask

    task automatic test_async_reset();
        fetch_en = 1'b1;
        @(negedge clk);
        checks++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 32'h8002_0500) begin errors++; $display("FAIL arst_pre_burst: en=%b addr=%h, required 1 80020500", mem_bus.mem_en, mem_bus.mem_addr); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_bus.mem_en !== 1'b0) begin errors++; $display("FAIL arst_mem_en: got %b, required 0", mem_bus.mem_en); end
        checks++; if (dec_bus.dec_valid !== 1'b0) begin errors++; $display("FAIL arst_dec_valid: got %b, required 0", dec_bus.dec_valid); end
        checks++; if (mem_bus.mem_addr !== START) begin errors++; $display("FAIL arst_mem_addr: got %h, required %h", mem_bus.mem_addr, START); end
        burst_obs.delete();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        checks++;
        if (burst_obs.size() != 1) begin
            errors++; $display("FAIL arst_restart: %0d burst starts, required 1", burst_obs.size());
        end else if (burst_obs[0] !== START) begin
            errors++; $display("FAIL arst_restart: addr %h, required %h", burst_obs[0], START);
        end
        push_exp(START, 4);
        repeat (4) pop_one("arst_order");
        checks++; if (dec_bus.dec_valid !== 1'b0) begin errors++; $display("FAIL arst_empty: dec_valid %b, required 0", dec_bus.dec_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        cleanup(32'h8002_0200);
        test_backpressure();
        cleanup(32'h8002_0300);
        test_redirect();
        cleanup(32'h8000_0000);
        test_fault();
        cleanup(32'h8002_0500);
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
